// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and defaults for the burst generator and the
//                sliding-window rise detector (seqcheck).
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

   // Burst generator phase encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      HIGH  = 2'd2,
      LOW   = 2'd3
   } burst_state_t;

   // Default width of config fields and phase counters
   localparam int CW_DEFAULT = 8;

   // Detector defaults: window length and required rise count
   localparam int SEQ_W_DEFAULT = 5;
   localparam int SEQ_K_DEFAULT = 3;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : seq_phase_cnt
//  Description : Loadable down-counter that times one burst phase. Loaded with
//                (length-1); zero flags the last cycle of the phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_phase_cnt #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic          zero
);

   logic [CW-1:0] r_cnt;

   // Load has priority; otherwise count down and hold at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign zero = (r_cnt == '0);

endmodule : seq_phase_cnt
`default_nettype wire

// File: rtl/seq_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_burst_gen
//  Description : Programmable burst generator. On an accepted start it emits
//                cfg_count pulses (cfg_high cycles high, cfg_low cycles low)
//                after cfg_delay cycles, with a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_burst_gen
   import seq_pkg::*;
#(
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] cfg_count,
   input  logic [CW-1:0] cfg_high,
   input  logic [CW-1:0] cfg_low,
   input  logic [CW-1:0] cfg_delay,
   output logic          out_sig,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] pulses_sent
);

   burst_state_t  r_state;
   burst_state_t  w_next;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_high_m1;
   logic [CW-1:0] r_low_m1;
   logic          w_accept;
   logic          w_load;
   logic [CW-1:0] w_load_val;
   logic          w_done_next;
   logic          w_zero;
   logic [CW-1:0] w_cfg_high_m1;
   logic [CW-1:0] w_cfg_low_m1;

   // A zero width is stretched to one cycle so every pulse and gap is visible
   assign w_cfg_high_m1 = (cfg_high == '0) ? '0 : cfg_high - CW'(1);
   assign w_cfg_low_m1  = (cfg_low  == '0) ? '0 : cfg_low  - CW'(1);
   assign w_accept      = (r_state == IDLE) && start && !abort;

   // Next-state, phase-counter reload and completion decode
   always_comb begin
      w_next      = r_state;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_done_next = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_load = 1'b1;
               if (cfg_count == '0) begin
                  // Empty burst: one DELAY cycle, then report done
                  w_next     = DELAY;
                  w_load_val = '0;
               end else if (cfg_delay != '0) begin
                  w_next     = DELAY;
                  w_load_val = cfg_delay - CW'(1);
               end else begin
                  w_next     = HIGH;
                  w_load_val = w_cfg_high_m1;
               end
            end
         end
         DELAY: begin
            if (abort) begin
               w_next = IDLE;
            end else if (w_zero) begin
               if (r_count == '0) begin
                  w_next      = IDLE;
                  w_done_next = 1'b1;
               end else begin
                  w_next     = HIGH;
                  w_load     = 1'b1;
                  w_load_val = r_high_m1;
               end
            end
         end
         HIGH: begin
            if (abort) begin
               w_next = IDLE;
            end else if (w_zero) begin
               if (pulses_sent == r_count) begin
                  w_next      = IDLE;
                  w_done_next = 1'b1;
               end else begin
                  w_next     = LOW;
                  w_load     = 1'b1;
                  w_load_val = r_low_m1;
               end
            end
         end
         LOW: begin
            if (abort) begin
               w_next = IDLE;
            end else if (w_zero) begin
               w_next     = HIGH;
               w_load     = 1'b1;
               w_load_val = r_high_m1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Single phase timer, reloaded at every phase entry
   seq_phase_cnt #(
      .CW (CW)
   ) u_phase_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load),
      .load_val (w_load_val),
      .en       (r_state != IDLE),
      .zero     (w_zero)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Latch adjusted configuration at accept; held for the whole burst
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_high_m1 <= '0;
         r_low_m1  <= '0;
      end else if (w_accept) begin
         r_count   <= cfg_count;
         r_high_m1 <= w_cfg_high_m1;
         r_low_m1  <= w_cfg_low_m1;
      end
   end

   // Registered outputs: out_sig follows the next state, done pulses once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sig <= 1'b0;
         done    <= 1'b0;
      end else begin
         out_sig <= (w_next == HIGH);
         done    <= w_done_next;
      end
   end

   // Rise counter: cleared at accept, bumped on every entry into HIGH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulses_sent <= '0;
      end else if (w_accept) begin
         pulses_sent <= (w_next == HIGH) ? CW'(1) : '0;
      end else if ((w_next == HIGH) && (r_state != HIGH)) begin
         pulses_sent <= pulses_sent + CW'(1);
      end
   end

   assign busy = (r_state != IDLE);

endmodule : seq_burst_gen
`default_nettype wire
